// File: rtl/cpu_pkg.sv
// Shared opcode classes and writeback-stage FSM encoding.
package cpu_pkg;

  localparam int OPC_LOAD    = 1;
  localparam int OPC_STORE   = 4;
  localparam int OPC_ALU_MAX = 4;  // every opcode above this is a NOP

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts memory-wait cycles; expired flags the cycle whose increment would reach limit.
module mem_timeout_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == limit - CNT_W'(1));

endmodule

// File: rtl/mem_wb_unit.sv
// Memory/writeback stage: issues loads and stores, writes results back, flags memory timeouts.
module mem_wb_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 4,
  parameter int OPC_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               carry_in,
  input  logic [DATA_W-1:0]  store_data,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               write_back_en,
  output logic [RADDR_W-1:0] write_back_addr,
  output logic [DATA_W-1:0]  write_back_data,
  output logic               carry_flag,
  output logic               mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t state;
  logic   is_load, is_store, is_alu, xfer;
  logic   cnt_en, cnt_clr, expired;

  assign is_load  = (opcode == OPC_W'(OPC_LOAD));
  assign is_store = (opcode == OPC_W'(OPC_STORE));
  assign is_alu   = (opcode <= OPC_W'(OPC_ALU_MAX)) && !is_load && !is_store;
  assign in_ready = (state == ST_IDLE);
  assign xfer     = in_valid && in_ready;

  // The counter only advances on MEM cycles without an ack, so an ack always beats the timeout.
  assign cnt_en  = (state == ST_MEM) && !mem_ack;
  assign cnt_clr = (state != ST_MEM);

  mem_timeout_ctr #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (cnt_en),
    .clear   (cnt_clr),
    .limit   (CNT_W'(MEM_TIMEOUT)),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      write_back_en   <= 1'b0;
      write_back_addr <= '0;
      write_back_data <= '0;
      carry_flag      <= 1'b0;
      mem_err         <= 1'b0;
    end else begin
      write_back_en <= 1'b0;
      mem_err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer && (is_load || is_store)) begin
            state           <= ST_MEM;
            mem_req         <= 1'b1;
            mem_we          <= is_store;
            mem_addr        <= alu_out;
            mem_wdata       <= store_data;
            write_back_addr <= rd_addr;
          end else if (xfer && is_alu) begin
            state           <= ST_WB;
            write_back_en   <= 1'b1;
            write_back_addr <= rd_addr;
            write_back_data <= alu_out;
            carry_flag      <= carry_in;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              state           <= ST_WB;
              write_back_en   <= 1'b1;
              write_back_data <= mem_rdata;
            end else begin
              state <= ST_IDLE;
            end
          end else if (expired) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data and address width.
REQ-002 SHALL have parameter RADDR_W, default 4, meaning register-file address width.
REQ-003 SHALL have parameter OPC_W, default 4, meaning opcode width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, meaning maximum number of cycles to wait for mem_ack.
REQ-005 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: in_valid  in  1  upstream (execute stage) result is valid.
REQ-008 Port: in_ready  out  1  unit accepts an upstream result this cycle.
REQ-009 Port: opcode  in  OPC_W  instruction opcode.
REQ-010 Port: alu_out  in  DATA_W  ALU result; also used as the memory address.
REQ-011 Port: carry_in  in  1  ALU carry.
REQ-012 Port: store_data  in  DATA_W  register data to store.
REQ-013 Port: rd_addr  in  RADDR_W  destination register.
REQ-014 Port: mem_req  out  1  memory request; held high until ack.
REQ-015 Port: mem_we  out  1  1 = store, 0 = load.
REQ-016 Port: mem_addr / mem_wdata  out  DATA_W each  request address and write data.
REQ-017 Port: mem_ack  in  1  request complete; mem_rdata is valid in the same cycle.
REQ-018 Port: mem_rdata  in  DATA_W  load data.
REQ-019 Port: write_back_en / write_back_addr / write_back_data  out  1 / RADDR_W / DATA_W  register-file write port.
REQ-020 Port: carry_flag  out  1  architectural carry flag.
REQ-021 Port: mem_err  out  1  one-cycle pulse on memory timeout.

Function
REQ-022 Opcode classes: LOAD = 1, STORE = 4, ALU = every other value < 5, NOP = any value >= 5.
REQ-023 FSM states SHALL be IDLE, MEM, WB.
REQ-024 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready; all inputs are captured on transfer.
REQ-025 IDLE -> MEM on a LOAD/STORE transfer; IDLE -> WB on an ALU transfer; on a NOP transfer the FSM stays in IDLE with no outputs asserted.
REQ-026 In MEM: mem_req = 1; mem_addr, mem_wdata and mem_we come from the captured values and are stable until ack.
REQ-027 On mem_ack in MEM: a LOAD captures mem_rdata and goes to WB; a STORE returns to IDLE with no register write.
REQ-028 In WB, write_back_en SHALL pulse for exactly one cycle, then the FSM returns to IDLE; write data = captured mem_rdata for LOAD, captured alu_out for ALU.
REQ-029 carry_flag SHALL update from the captured carry_in in the WB cycle of ALU ops only.
REQ-030 Latency from transfer to write_back_en: ALU = 1 cycle; LOAD = ack cycle + 1.
REQ-031 A wait counter (width clog2(MEM_TIMEOUT+1)) counts MEM cycles without ack; when it reaches MEM_TIMEOUT with no ack, the unit SHALL pulse mem_err, drop mem_req, return to IDLE, and perform no write.
REQ-032 mem_ack SHALL be ignored outside MEM.
REQ-033 An ack in the same cycle the counter reaches MEM_TIMEOUT SHALL win: normal completion, no mem_err.
REQ-034 A write to rd_addr = 0 SHALL still be issued; register-0 policy is left to the register file.

Reset
REQ-035 On rst: state = IDLE; counter = 0; in_ready = 1; write_back_en, mem_req, mem_we, carry_flag and mem_err = 0; all address and data outputs = 0.
REQ-036 Reset mid-MEM SHALL drop mem_req immediately (asynchronously); the in-flight op is discarded.

Structure
REQ-037 Opcode constants (LOAD, STORE, ALU_MAX) and the FSM state encoding SHALL live in the shared package cpu_pkg.
REQ-038 The timeout counter MAY be a sub-module, mem_timeout_ctr (enable, clear, limit, expired); all else is flat.

Verification
REQ-039 ALU op 2, alu_out = 0x0000_0005, rd = 3, carry = 1 -> next cycle write_back_en = 1, addr = 3, data = 5; carry_flag = 1.
REQ-040 LOAD, alu_out = 0x10, ack after 3 cycles with rdata = 0xDEADBEEF -> mem_req held high for 3 cycles with mem_we = 0, then a write of 0xDEADBEEF.
REQ-041 STORE, addr = 0x20, data = 0xA5 -> mem_we = 1, mem_wdata = 0xA5, no write_back_en after ack.
REQ-042 LOAD, no ack, MEM_TIMEOUT = 15 -> mem_err pulses at MEM cycle 15, mem_req drops, no write.
REQ-043 rst asserted in the 2nd MEM cycle -> mem_req = 0 immediately, in_ready = 1 after release.
REQ-044 Back-to-back in_valid with opcodes 2, 1, 7 -> in_ready deasserts while busy; the NOP produces no outputs.
